// File: rtl/ika9958_cpu_regwr.sv
// ika9958_cpu_regwr
// -----------------
// CPU-side writer for the VDP register file. Turns Z80 port writes into
// single-cycle strobes for the register file, the palette and the VRAM
// address counter.
//   port #1 : two-byte direct register write / VRAM address setup
//   port #2 : two-byte palette write (entry taken from shadow R#16)
//   port #3 : indirect register write through shadow R#17
//   port #0 : ignored here
//
// Ports
//   i_EMUCLK    master clock
//   i_RST_n     synchronous active-low reset
//   i_WR, i_RD  one-cycle CPU write / read strobes
//   i_PORT      port select 0..3
//   i_DIN       CPU write data
//   o_REG_WE    register write strobe, with o_REG_ADDR / o_REG_DATA
//   o_PAL_WE    palette write strobe, with o_PAL_IDX / o_PAL_DATA {R,G,B}
//   o_VADDR_LD  VRAM address load strobe, with o_VADDR / o_VADDR_WR
//   o_PORT1_PH  port #1 second byte pending
//
// Parameter MAXREG: highest writable register number.
// Build option IKA9958_V9938_COMPAT_EN: V9938 register map (R#25..R#27 are
// not writable, highest register capped at 46).

module ika9958_cpu_regwr #(
    parameter int MAXREG = 46
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST_n,
    input  logic        i_WR,
    input  logic        i_RD,
    input  logic [1:0]  i_PORT,
    input  logic [7:0]  i_DIN,
    output logic        o_REG_WE,
    output logic [5:0]  o_REG_ADDR,
    output logic [7:0]  o_REG_DATA,
    output logic        o_PAL_WE,
    output logic [3:0]  o_PAL_IDX,
    output logic [8:0]  o_PAL_DATA,
    output logic        o_VADDR_LD,
    output logic [13:0] o_VADDR,
    output logic        o_VADDR_WR,
    output logic        o_PORT1_PH
);

`ifdef IKA9958_V9938_COMPAT_EN
    localparam int EFF_MAX = (MAXREG < 46) ? MAXREG : 46;
`else
    localparam int EFF_MAX = (MAXREG > 63) ? 63 : MAXREG;
`endif
    localparam logic [6:0] EFF_MAX7 = 7'(EFF_MAX);

    typedef enum logic { P1_IDLE, P1_HAVE1 } p1_state_t;
    typedef enum logic { P2_IDLE, P2_HAVE1 } p2_state_t;

    p1_state_t p1_q, p1_n;
    p2_state_t p2_q, p2_n;

    logic [7:0]  lat1_q, lat1_n;
    logic [2:0]  pal_r_q, pal_r_n;
    logic [2:0]  pal_b_q, pal_b_n;
    logic [7:0]  r16_q, r16_n;
    logic [7:0]  r17_q, r17_n;

    logic        reg_we_n;
    logic [5:0]  reg_addr_n;
    logic [7:0]  reg_data_n;
    logic        pal_we_n;
    logic [3:0]  pal_idx_n;
    logic [8:0]  pal_data_n;
    logic        vaddr_ld_n;
    logic [13:0] vaddr_n;
    logic        vaddr_wr_n;

    // Register number filter shared by port #1 and port #3 writes.
    function automatic logic reg_ok(input logic [5:0] a);
        logic ok;
        ok = ({1'b0, a} <= EFF_MAX7) && (a != 6'd24);
`ifdef IKA9958_V9938_COMPAT_EN
        if (a >= 6'd25 && a <= 6'd27) ok = 1'b0;
`endif
        return ok;
    endfunction

    always_comb begin
        logic       wreq;
        logic [5:0] wa;
        logic [7:0] wd;

        p1_n       = p1_q;
        p2_n       = p2_q;
        lat1_n     = lat1_q;
        pal_r_n    = pal_r_q;
        pal_b_n    = pal_b_q;
        r16_n      = r16_q;
        r17_n      = r17_q;
        reg_we_n   = 1'b0;
        reg_addr_n = o_REG_ADDR;
        reg_data_n = o_REG_DATA;
        pal_we_n   = 1'b0;
        pal_idx_n  = o_PAL_IDX;
        pal_data_n = o_PAL_DATA;
        vaddr_ld_n = 1'b0;
        vaddr_n    = o_VADDR;
        vaddr_wr_n = o_VADDR_WR;
        wreq       = 1'b0;
        wa         = 6'd0;
        wd         = 8'd0;

        if (i_WR) begin
            case (i_PORT)
                2'd1: begin
                    if (p1_q == P1_IDLE) begin
                        lat1_n = i_DIN;
                        p1_n   = P1_HAVE1;
                    end else begin
                        p1_n = P1_IDLE;
                        if (i_DIN[7]) begin
                            wreq = 1'b1;
                            wa   = i_DIN[5:0];
                            wd   = lat1_q;
                        end else begin
                            vaddr_ld_n = 1'b1;
                            vaddr_n    = {i_DIN[5:0], lat1_q};
                            vaddr_wr_n = i_DIN[6];
                        end
                    end
                end
                2'd2: begin
                    if (p2_q == P2_IDLE) begin
                        pal_r_n = i_DIN[6:4];
                        pal_b_n = i_DIN[2:0];
                        p2_n    = P2_HAVE1;
                    end else begin
                        pal_we_n    = 1'b1;
                        pal_idx_n   = r16_q[3:0];
                        pal_data_n  = {pal_r_q, i_DIN[2:0], pal_b_q};
                        // Palette pointer auto-increment; not a register write.
                        r16_n[3:0]  = r16_q[3:0] + 4'd1;
                        p2_n        = P2_IDLE;
                    end
                end
                2'd3: begin
                    wa   = r17_q[5:0];
                    wd   = i_DIN;
                    // R#17 cannot rewrite itself indirectly.
                    wreq = (r17_q[5:0] != 6'd17);
                    // Pointer advances whether or not the write is accepted.
                    if (!r17_q[7]) r17_n[5:0] = r17_q[5:0] + 6'd1;
                end
                default: ;
            endcase
        end else if (i_RD && i_PORT == 2'd1) begin
            // Status read resynchronises the two-byte sequence.
            p1_n = P1_IDLE;
        end

        if (wreq && reg_ok(wa)) begin
            reg_we_n   = 1'b1;
            reg_addr_n = wa;
            reg_data_n = wd;
            if (wa == 6'd16) begin
                r16_n = wd;
                p2_n  = P2_IDLE;
            end
            if (wa == 6'd17) r17_n = wd;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            p1_q       <= P1_IDLE;
            p2_q       <= P2_IDLE;
            lat1_q     <= 8'd0;
            pal_r_q    <= 3'd0;
            pal_b_q    <= 3'd0;
            r16_q      <= 8'd0;
            r17_q      <= 8'd0;
            o_REG_WE   <= 1'b0;
            o_REG_ADDR <= 6'd0;
            o_REG_DATA <= 8'd0;
            o_PAL_WE   <= 1'b0;
            o_PAL_IDX  <= 4'd0;
            o_PAL_DATA <= 9'd0;
            o_VADDR_LD <= 1'b0;
            o_VADDR    <= 14'd0;
            o_VADDR_WR <= 1'b0;
        end else begin
            p1_q       <= p1_n;
            p2_q       <= p2_n;
            lat1_q     <= lat1_n;
            pal_r_q    <= pal_r_n;
            pal_b_q    <= pal_b_n;
            r16_q      <= r16_n;
            r17_q      <= r17_n;
            o_REG_WE   <= reg_we_n;
            o_REG_ADDR <= reg_addr_n;
            o_REG_DATA <= reg_data_n;
            o_PAL_WE   <= pal_we_n;
            o_PAL_IDX  <= pal_idx_n;
            o_PAL_DATA <= pal_data_n;
            o_VADDR_LD <= vaddr_ld_n;
            o_VADDR    <= vaddr_n;
            o_VADDR_WR <= vaddr_wr_n;
        end
    end

    assign o_PORT1_PH = (p1_q == P1_HAVE1);

endmodule

// File: doc/ika9958_cpu_regwr.md
Name: ika9958_cpu_regwr

Overview:
- CPU-side writer for the VDP register file.
- Decodes Z80 port writes into single-cycle register-write, palette-write and VRAM-address-load strobes:
  - port #1: two-byte direct register write or VRAM address setup
  - port #2: two-byte palette write
  - port #3: indirect register write through R#17
- Keeps shadow copies of R#16 and R#17, because it needs their values.
- Sits between the CPU bus synchroniser and the register file, which latches on o_REG_WE.

Parameters:
- MAXREG, 46, highest writable register number; writes to higher numbers are dropped.

Ports:
- i_EMUCLK  in  1  master clock
- i_RST_n  in  1  reset; synchronous to i_EMUCLK, active-low
- i_WR  in  1  one-cycle CPU write strobe
- i_RD  in  1  one-cycle CPU read strobe
- i_PORT  in  2  port select, 0..3
- i_DIN  in  8  CPU write data
- o_REG_WE  out  1  register write strobe
- o_REG_ADDR  out  6  register number
- o_REG_DATA  out  8  register data
- o_PAL_WE  out  1  palette write strobe
- o_PAL_IDX  out  4  palette entry
- o_PAL_DATA  out  9  palette data {R[2:0],G[2:0],B[2:0]}
- o_VADDR_LD  out  1  VRAM address load strobe
- o_VADDR  out  14  VRAM address A13..A0
- o_VADDR_WR  out  1  1 = write setup, 0 = read setup
- o_PORT1_PH  out  1  port #1 second-byte pending (debug)

Behaviour:
- Reset (i_RST_n = 0 at a clock edge):
  - all outputs 0
  - shadow R16 = 0, shadow R17 = 0
  - byte latches = 0
  - both phase flags cleared
- Reset mid-sequence discards any pending first byte.
- All outputs are registered. Each strobe is high for exactly one cycle, the cycle after the triggering i_WR cycle. Address and data outputs hold until the next strobe of the same kind.
- Port #1 FSM, states P1_IDLE and P1_HAVE1:
  - P1_IDLE + write: latch i_DIN into lat1, go to P1_HAVE1.
  - P1_HAVE1 + write with i_DIN[7] = 1: register write; addr = i_DIN[5:0], data = lat1; go to P1_IDLE.
  - P1_HAVE1 + write with i_DIN[7] = 0: o_VADDR = {i_DIN[5:0], lat1}, o_VADDR_WR = i_DIN[6], pulse o_VADDR_LD; go to P1_IDLE.
  - i_RD on port #1 (status read) in any state: go to P1_IDLE.
  - i_WR and i_RD in the same cycle: i_RD is ignored.
- Port #2 FSM, states P2_IDLE and P2_HAVE1:
  - First byte: latch {R = i_DIN[6:4], B = i_DIN[2:0]}.
  - Second byte: G = i_DIN[2:0]; pulse o_PAL_WE with o_PAL_IDX = shadow R16[3:0].
  - After the second byte, shadow R16[3:0] increments, wrapping 15 -> 0. This increment does not generate an o_REG_WE.
- Port #3 (indirect write):
  - addr = R17[5:0], data = i_DIN.
  - If R17[7] = 0, R17[5:0] increments after the write, wrapping 63 -> 0; R17[7:6] are unchanged.
  - The increment happens even when the write is dropped.
  - An indirect write whose target is 17 is dropped.
- Write filter, applied to every register write:
  - addr > MAXREG: dropped, no o_REG_WE.
  - addr 24: dropped.
  - Otherwise o_REG_WE pulses.
- Shadow update: any accepted write to R16 or R17, through port #1 or port #3, updates the matching shadow in the same cycle as o_REG_WE.
- An accepted write to R16 also clears the port #2 phase.
- Port #0 writes and reads are ignored by this block.
- i_RD on ports 0, 2 and 3 has no effect.

Optional Feature:
- Macro: IKA9958_V9938_COMPAT_EN.
- Defined:
  - Register writes to 25, 26 and 27 are also dropped.
  - The effective maximum register is min(MAXREG, 46); V9938 register map.
- Undefined: registers 25-27 are writable; V9958 behaviour.

Test Plan:
- Reset, then port #1 writes 0x5A, 0x87 -> exactly one o_REG_WE, one cycle after the second strobe, addr 7, data 0x5A; o_PORT1_PH back to 0.
- Port #1 writes 0x34, 0x52 -> o_VADDR_LD, o_VADDR = 0x1234, o_VADDR_WR = 1, no o_REG_WE.
- Port #1 write 0x12, then port #1 read, then write 0x8F -> 0x8F is taken as a first byte; no strobe; o_PORT1_PH = 1.
- Set R17 = 0x2D via port #1, then port #3 writes 0xAA, 0xBB, 0xCC, 0xDD:
  - 0xAA -> R45
  - 0xBB -> R46
  - 0xCC -> dropped (R47 > MAXREG)
  - 0xDD -> dropped (R48 > MAXREG)
  - shadow R17 ends at 0x31.
  - Repeat with R17 = 0x91: one write to R17 is dropped and R17 does not increment.
- R16 = 0x0F, then port #2 writes 0x57, 0x03, 0x70, 0x01:
  - first pulse: idx 15, data {5,3,7} = 9'b101_011_111
  - second pulse: idx 0, data {7,1,0}
- Port #1 writes 0x11, 0x99 (reg 25) -> o_REG_WE when IKA9958_V9938_COMPAT_EN is undefined, no strobe when defined. Assert i_RST_n = 0 between first and second bytes -> no strobe.
